// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
//   NUM_DIGITS / DIGIT_MAX : input format (three packed BCD digits, 0..9)
//   ITER                   : number of CONV cycles per valid conversion
//   ACC_W                  : binary accumulator width (holds 0..999)
//   state_t                : converter FSM state type
//   digits_valid()         : true when every digit of a packed code is <= DIGIT_MAX
package bcd_pkg;

    localparam int         NUM_DIGITS = 3;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ITER       = 4'd12;
    localparam int         BCD_W      = 4 * NUM_DIGITS;
    localparam int         ACC_W      = 10;

    // The 10-bit result is complete after ACC_W shifts; at that point the BCD
    // register is already zero.  The remaining ITER-ACC_W steps therefore
    // leave the accumulator untouched so its LSBs are not shifted away.
    localparam logic [3:0] SHIFT_STOP = ITER - 4'(ACC_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digits_valid(input logic [BCD_W-1:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (code[4*i +: 4] > DIGIT_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit.
//   digit_in  : digit value after the right shift
//   digit_out : digit_in - 3 when digit_in >= 8, else digit_in
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd8) ? (digit_in - 4'd3) : digit_in;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential three-digit BCD to 8-bit binary converter (reverse double dabble).
//   clk, rst : system clock, asynchronous active-high reset
//   start    : conversion request, sampled only in IDLE
//   bcd_in   : {hundreds, tens, units} packed BCD, captured on the accepting edge
//   busy     : high in CONV and DONE
//   done     : one-cycle pulse, dout/err/ovf valid
//   dout     : binary result (saturates at 255, DEFAULT_VAL on invalid input)
//   err      : last request contained a digit > 9
//   ovf      : last request's value exceeded 255
//
// state | meaning
// IDLE  | waiting for start; invalid codes jump straight to DONE
// CONV  | one shift/adjust step per cycle, ITER cycles
// DONE  | one-cycle done pulse, results registered on entry
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter logic [7:0] DEFAULT_VAL = 8'd35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    output logic             busy,
    output logic             done,
    output logic [7:0]       dout,
    output logic             err,
    output logic             ovf
);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q;
    logic [ACC_W-1:0]   acc_q;
    logic [3:0]         cnt_q;

    logic               in_valid;
    logic               shift_en;
    logic [BCD_W+ACC_W-1:0] shifted;
    logic [BCD_W-1:0]   bcd_step;
    logic [ACC_W-1:0]   acc_next;

    assign in_valid = digits_valid(bcd_in);
    assign shift_en = (cnt_q > SHIFT_STOP);
    assign shifted  = {bcd_q, acc_q} >> 1;
    assign acc_next = shift_en ? shifted[ACC_W-1:0] : acc_q;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (shifted[ACC_W + 4*g +: 4]),
            .digit_out (bcd_step[4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = in_valid ? CONV : DONE;
            end
            CONV: begin
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            dout  <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (in_valid) begin
                            bcd_q <= bcd_in;
                            acc_q <= '0;
                            cnt_q <= ITER;
                        end else begin
                            dout <= DEFAULT_VAL;
                            err  <= 1'b1;
                            ovf  <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (shift_en) begin
                        bcd_q <= bcd_step;
                        acc_q <= acc_next;
                    end
                    if (cnt_q == 4'd1) begin
                        err <= 1'b0;
                        if (acc_next > 10'd255) begin
                            dout <= 8'd255;
                            ovf  <= 1'b1;
                        end else begin
                            dout <= acc_next[7:0];
                            ovf  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed corner cases, protocol checks,
// random codes and a full sweep of all 4096 input codes against a decimal model.
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [7:0]  dout;
    logic        err;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_bin #(.DEFAULT_VAL(8'd35)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .err    (err),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns {ovf, err, dout} from decimal arithmetic on the three digits.
    function automatic logic [9:0] model(input logic [11:0] code);
        int h, t, u, v;
        h = int'(code[11:8]);
        t = int'(code[7:4]);
        u = int'(code[3:0]);
        if (h > 9 || t > 9 || u > 9) return {1'b0, 1'b1, 8'd35};
        v = 100 * h + 10 * t + u;
        if (v > 255) return {1'b1, 1'b0, 8'd255};
        return {1'b0, 1'b0, 8'(v)};
    endfunction

    // Issues one request from IDLE; lat = negedge index (after the accepting
    // edge) at which done is first seen, 0 if never within the budget.
    task automatic req(input logic [11:0] code, output int lat, output int busy_n, output int done_n);
        lat = 0;
        busy_n = 0;
        done_n = 0;
        @(negedge clk);
        bcd_in = code;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) lat = n;
            end
            if (lat != 0 && !busy) break;
        end
    endtask

    task automatic check_req(input string tag, input logic [11:0] code);
        int lat, busy_n, done_n, exp_lat;
        logic [9:0] exp;
        exp     = model(code);
        exp_lat = exp[8] ? 1 : 13;
        req(code, lat, busy_n, done_n);
        check({tag, ".lat"},  lat,    exp_lat);
        check({tag, ".busy"}, busy_n, exp_lat);
        check({tag, ".ndone"}, done_n, 1);
        check({tag, ".dout"}, dout,   exp[7:0]);
        check({tag, ".err"},  err,    exp[8]);
        check({tag, ".ovf"},  ovf,    exp[9]);
    endtask

    initial begin
        int ndone, pos1, pos2;
        logic [11:0] directed [8];
        directed = '{12'h035, 12'h255, 12'h256, 12'h999, 12'h0A5, 12'h10F, 12'h120, 12'h000};

        rst = 1'b1;
        start = 1'b0;
        bcd_in = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.dout", dout, 0);
        check("rst.err",  err,  0);
        check("rst.ovf",  ovf,  0);
        rst = 1'b0;

        foreach (directed[i]) check_req($sformatf("dir_%03h", directed[i]), directed[i]);

        // Results hold through idle cycles.
        check_req("hold_req", 12'h120);
        repeat (4) @(negedge clk);
        check("hold.dout", dout, 120);
        check("hold.err",  err,  0);

        // Second start during CONV is ignored.
        @(negedge clk);
        bcd_in = 12'h123;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        bcd_in = 12'h456;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ign.ndone", ndone, 1);
        check("ign.dout",  dout,  123);
        check("ign.busy",  busy,  0);

        // Reset in the middle of CONV aborts without done.
        @(negedge clk);
        bcd_in = 12'h200;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.dout", dout, 0);
        check("abort.err",  err,  0);
        check("abort.ovf",  ovf,  0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort.ndone", ndone, 0);
        check_req("after_abort", 12'h000);

        // start held high restarts on the first IDLE cycle after DONE.
        @(negedge clk);
        bcd_in = 12'h042;
        start  = 1'b1;
        @(posedge clk);
        #1;
        pos1 = 0;
        pos2 = 0;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (done) begin
                if (pos1 == 0) pos1 = n;
                else if (pos2 == 0) pos2 = n;
            end
            if (pos2 != 0) begin
                start = 1'b0;
                break;
            end
        end
        check("held.first",  pos1, 13);
        check("held.second", pos2, 27);
        check("held.dout",   dout, 42);
        repeat (3) @(negedge clk);
        check("held.idle", busy, 0);

        for (int i = 0; i < 200; i++) begin
            logic [11:0] code;
            code = 12'($urandom_range(0, 4095));
            check_req($sformatf("rnd_%03h", code), code);
        end

        for (int c = 0; c < 4096; c++) check_req($sformatf("sweep_%03h", c), 12'(c));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
